// File: rtl/score_tracker_pkg.sv
// Shared game-state encodings and BCD score limits for score_tracker and score consumers.
package score_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DIE  = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [6:0] MAX_SCORE = 7'd99;

  function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/score_tracker_bcd_counter2.sv
// Two-digit BCD counter that saturates at 99; clear takes priority over inc.
module bcd_counter2
  import score_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic       sat,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic       w_sat;

  assign w_sat = (bcd_value(r_tens, r_ones) == MAX_SCORE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (inc && !w_sat) begin
      if (r_ones == MAX_DIGIT) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign sat  = w_sat;
  assign ones = r_ones;
  assign tens = r_tens;

endmodule

// File: rtl/score_tracker.sv
// Game run FSM (IDLE/PLAY/DIE/OVER) with post-run start lockout and BCD score.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       point,
  input  logic       hit,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       slime_die,
  output logic [1:0] game_state
);

  game_state_t r_state;
  logic [7:0]  r_lock;
  logic        r_die;
  logic        w_accept;
  logic        w_inc;
  logic        w_sat;

  assign w_accept = start && ((r_state == ST_IDLE) || ((r_state == ST_OVER) && (r_lock == '0)));
  assign w_inc    = (r_state == ST_PLAY) && point && !w_sat;

  // A point arriving with hit is still counted: the counter and FSM update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lock  <= '0;
      r_die   <= 1'b0;
    end else begin
      r_die <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_PLAY;
        ST_PLAY: begin
          if (hit) begin
            r_state <= ST_DIE;
            r_die   <= 1'b1;
          end
        end
        ST_DIE: begin
          r_state <= ST_OVER;
          r_lock  <= 8'(LOCKOUT_CYC);
        end
        ST_OVER: begin
          if (r_lock != '0) r_lock <= r_lock - 8'd1;
          else if (start)   r_state <= ST_PLAY;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  bcd_counter2 u_score (
    .clk   (clk),
    .rst   (rst),
    .clear (w_accept),
    .inc   (w_inc),
    .sat   (w_sat),
    .ones  (score_0),
    .tens  (score_1)
  );

  assign slime_die  = r_die;
  assign game_state = r_state;

endmodule

// File: tb/tb_score_tracker.sv
// Directed, table-driven bench for score_tracker with LOCKOUT_CYC=4.
module tb_score_tracker;

  logic       clk = 1'b0;
  logic       rst, start, point, hit;
  logic [3:0] score_0, score_1;
  logic       slime_die;
  logic [1:0] game_state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  score_tracker #(.LOCKOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .point      (point),
    .hit        (hit),
    .score_0    (score_0),
    .score_1    (score_1),
    .slime_die  (slime_die),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, point, hit;
    logic [1:0] st;
    logic [3:0] s1, s0;
    logic       die;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, s, p, h, input logic [1:0] st,
                      input logic [3:0] s1, s0, input logic die);
    vec_t v;
    v.rst = r; v.start = s; v.point = p; v.hit = h;
    v.st = st; v.s1 = s1; v.s0 = s0; v.die = die;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, s, p, h);
    rst = r; start = s; point = p; hit = h;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; point = 1'b0; hit = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st,
                         input logic [3:0] s1, s0, input logic die);
    chk({tag, ".state"}, game_state, st);
    chk({tag, ".s1"}, score_1, s1);
    chk({tag, ".s0"}, score_0, s0);
    chk({tag, ".die"}, slime_die, die);
  endtask

  initial begin
    int exp_score;
    rst = 1'b1; start = 1'b0; point = 1'b0; hit = 1'b0;
    #1;

    //    rst start point hit   state s1 s0 die
    addv(1, 0, 0, 0, 2'd0, 0, 0, 0);   // reset
    addv(0, 0, 1, 0, 2'd0, 0, 0, 0);   // point ignored in IDLE
    addv(0, 0, 0, 1, 2'd0, 0, 0, 0);   // hit ignored in IDLE
    addv(0, 1, 0, 0, 2'd1, 0, 0, 0);   // start -> PLAY
    addv(0, 0, 1, 0, 2'd1, 0, 1, 0);
    addv(0, 1, 1, 0, 2'd1, 0, 2, 0);   // start ignored in PLAY
    addv(0, 0, 1, 0, 2'd1, 0, 3, 0);
    addv(0, 0, 1, 0, 2'd1, 0, 4, 0);
    addv(0, 0, 1, 0, 2'd1, 0, 5, 0);
    addv(0, 0, 1, 0, 2'd1, 0, 6, 0);
    addv(0, 0, 1, 0, 2'd1, 0, 7, 0);
    addv(0, 0, 1, 1, 2'd2, 0, 8, 1);   // point+hit at 07 -> DIE shows 08
    addv(0, 0, 1, 1, 2'd3, 0, 8, 0);   // OVER+0, inputs ignored in DIE
    addv(0, 1, 0, 0, 2'd3, 0, 8, 0);   // start at OVER+0 ignored
    addv(0, 1, 0, 0, 2'd3, 0, 8, 0);   // start at OVER+1 ignored
    addv(0, 0, 1, 1, 2'd3, 0, 8, 0);   // OVER+2, frozen
    addv(0, 1, 0, 0, 2'd3, 0, 8, 0);   // start at OVER+3 ignored
    addv(0, 1, 0, 0, 2'd1, 0, 0, 0);   // start at OVER+4 accepted
    addv(0, 0, 1, 0, 2'd1, 0, 1, 0);
    addv(0, 0, 0, 1, 2'd2, 0, 1, 1);
    addv(0, 0, 0, 0, 2'd3, 0, 1, 0);
    addv(1, 0, 0, 0, 2'd0, 0, 0, 0);
    addv(0, 1, 0, 0, 2'd1, 0, 0, 0);
    addv(0, 0, 1, 0, 2'd1, 0, 1, 0);
    addv(1, 1, 1, 1, 2'd0, 0, 0, 0);   // rst with hit in PLAY: no pulse
    addv(0, 0, 0, 0, 2'd0, 0, 0, 0);
    addv(0, 1, 0, 0, 2'd1, 0, 0, 0);
    addv(0, 0, 0, 1, 2'd2, 0, 0, 1);
    addv(1, 0, 0, 0, 2'd0, 0, 0, 0);   // rst during DIE cuts the pulse
    addv(0, 0, 0, 0, 2'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].point, vecs[i].hit);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].s1, vecs[i].s0, vecs[i].die);
    end

    // Run with 12 points, then hit.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
    chk_all("run12.play", 2'd1, 1, 2, 0);
    step(0, 0, 0, 1);
    chk_all("run12.die", 2'd2, 1, 2, 1);
    step(0, 0, 0, 0);
    chk_all("run12.over", 2'd3, 1, 2, 0);

    // 105 points: carry through 09->10 and saturation at 99.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    exp_score = 0;
    for (int i = 0; i < 105; i++) begin
      step(0, 0, 1, 0);
      if (exp_score < 99) exp_score++;
      chk("sat.s1", score_1, exp_score / 10);
      chk("sat.s0", score_0, exp_score % 10);
    end
    chk("sat.state", game_state, 1);
    step(0, 0, 0, 1);
    chk_all("sat.die", 2'd2, 9, 9, 1);

    // IDLE ignores 10 point and 10 hit pulses.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      chk_all("idle.pt", 2'd0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk_all("idle.hit", 2'd0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
